register_file: RTL and testbench

//  Architectural register file with rename tags: 32 x 32-bit values plus per-register busy bit and RoB tag.

---
 rtl/register_file.sv | 119 +++++++++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (busy bit + RoB tag).
// Optional same-cycle commit forwarding on operand reads: define REGFILE_COMMIT_BYPASS_EN.
module register_file #(
    parameter int                       REG_WIDTH    = 5,
    parameter int                       EX_REG_WIDTH = 6,
    parameter logic [EX_REG_WIDTH-1:0]  NON_REG      = 6'b100000,
    parameter int                       RoB_WIDTH    = 8,
    parameter int                       EX_RoB_WIDTH = 9,
    parameter logic [EX_RoB_WIDTH-1:0]  NON_DEP      = 9'b100000000
) (
    input  logic                     Sys_clk,
    input  logic                     Sys_rst,
    input  logic                     Sys_rdy,
    input  logic                     DPRF_en,
    input  logic [EX_REG_WIDTH-1:0]  DPRF_rs1,
    input  logic [EX_REG_WIDTH-1:0]  DPRF_rs2,
    input  logic [EX_REG_WIDTH-1:0]  DPRF_rd,
    input  logic [RoB_WIDTH-1:0]     DPRF_RoB_index,
    output logic [EX_RoB_WIDTH-1:0]  RFDP_Qj,
    output logic [EX_RoB_WIDTH-1:0]  RFDP_Qk,
    output logic [31:0]              RFDP_Vj,
    output logic [31:0]              RFDP_Vk,
    input  logic                     RoBRF_en,
    input  logic [EX_REG_WIDTH-1:0]  RoBRF_rd,
    input  logic [RoB_WIDTH-1:0]     RoBRF_RoB_index,
    input  logic [31:0]              RoBRF_value,
    input  logic                     RoBRF_pre_judge
);

    localparam int NUM_REGS = 1 << REG_WIDTH;

    typedef struct packed {
        logic [EX_RoB_WIDTH-1:0] q;
        logic [31:0]             v;
    } operand_t;

    logic [31:0]          value_q [NUM_REGS];
    logic [31:0]          value_d [NUM_REGS];
    logic                 busy_q  [NUM_REGS];
    logic                 busy_d  [NUM_REGS];
    logic [RoB_WIDTH-1:0] tag_q   [NUM_REGS];
    logic [RoB_WIDTH-1:0] tag_d   [NUM_REGS];

    operand_t op1, op2;

    // Any index with the extension bit set is treated as "no register", not just NON_REG.
    function automatic operand_t read_src(input logic [EX_REG_WIDTH-1:0] s);
        operand_t                r;
        logic [REG_WIDTH-1:0]    idx;
        idx = s[REG_WIDTH-1:0];
        r.q = NON_DEP;
        r.v = '0;
        if (!s[REG_WIDTH] && idx != '0) begin
            r.v = value_q[idx];
            if (busy_q[idx]) begin
                r.q = {1'b0, tag_q[idx]};
`ifdef REGFILE_COMMIT_BYPASS_EN
                if (RoBRF_en && s == RoBRF_rd && tag_q[idx] == RoBRF_RoB_index) begin
                    r.q = NON_DEP;
                    r.v = RoBRF_value;
                end
`endif
            end
        end
        return r;
    endfunction

    always_comb begin
        op1 = read_src(DPRF_rs1);
        op2 = read_src(DPRF_rs2);
    end

    assign RFDP_Qj = op1.q;
    assign RFDP_Vj = op1.v;
    assign RFDP_Qk = op2.q;
    assign RFDP_Vk = op2.v;

    // Entry 0 is never touched here, so x0 stays zero and never busy.
    always_comb begin
        // NOTE: default every next-state variable first so no path leaves it unassigned (no latches).
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (Sys_rdy) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (RoBRF_en && RoBRF_rd == EX_REG_WIDTH'(i)) begin
                    value_d[i] = RoBRF_value;
                end
                if (!RoBRF_pre_judge) begin
                    busy_d[i] = 1'b0;
                end else if (DPRF_en && DPRF_rd == EX_REG_WIDTH'(i)) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = DPRF_RoB_index;
                end else if (RoBRF_en && RoBRF_rd == EX_REG_WIDTH'(i)
                             && busy_q[i] && tag_q[i] == RoBRF_RoB_index) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    // NOTE: this array is flop-based architectural state that must read as zero after reset,
    // so it is reset explicitly rather than left to a RAM macro.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table of single-cycle vectors plus hand-written
// reset and commit-bypass sequences. Honours REGFILE_COMMIT_BYPASS_EN for the bypass check.
module tb_register_file;

    localparam logic [5:0] NR = 6'b100000;
    localparam logic [8:0] ND = 9'b100000000;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        dp_en;
    logic [5:0]  rs1, rs2, dp_rd;
    logic [7:0]  dp_idx;
    logic [8:0]  qj, qk;
    logic [31:0] vj, vk;
    logic        c_en;
    logic [5:0]  c_rd;
    logic [7:0]  c_idx;
    logic [31:0] c_val;
    logic        pre_judge;

    int n_checks = 0;
    int n_pass   = 0;

    register_file dut (
        .Sys_clk        (clk),
        .Sys_rst        (rst_n),
        .Sys_rdy        (rdy),
        .DPRF_en        (dp_en),
        .DPRF_rs1       (rs1),
        .DPRF_rs2       (rs2),
        .DPRF_rd        (dp_rd),
        .DPRF_RoB_index (dp_idx),
        .RFDP_Qj        (qj),
        .RFDP_Qk        (qk),
        .RFDP_Vj        (vj),
        .RFDP_Vk        (vk),
        .RoBRF_en       (c_en),
        .RoBRF_rd       (c_rd),
        .RoBRF_RoB_index(c_idx),
        .RoBRF_value    (c_val),
        .RoBRF_pre_judge(pre_judge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        dp_en;
        logic [5:0]  dp_rd;
        logic [7:0]  dp_idx;
        logic        c_en;
        logic [5:0]  c_rd;
        logic [7:0]  c_idx;
        logic [31:0] c_val;
        logic        pre_judge;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [8:0]  exp_qj;
        logic [31:0] exp_vj;
        logic [8:0]  exp_qk;
        logic [31:0] exp_vk;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; dp_en = 1'b0; dp_rd = NR; dp_idx = '0;
        c_en = 1'b0; c_rd = NR; c_idx = '0; c_val = '0; pre_judge = 1'b1;
        rs1 = NR; rs2 = NR;
    endtask

    initial begin
        // rdy dp_en dp_rd dp_idx | c_en c_rd c_idx c_val pj | rs1 rs2 | exp qj vj qk vk
        vecs[0]  = '{1, 0, NR,    8'h00, 0, NR,    8'h00, 32'h0,    1, 6'd0,  NR,    ND,     32'h0,  ND,     32'h0};
        vecs[1]  = '{1, 1, 6'd3,  8'h07, 0, NR,    8'h00, 32'h0,    1, 6'd3,  6'd5,  ND,     32'h0,  ND,     32'h0};
        vecs[2]  = '{1, 0, NR,    8'h00, 1, 6'd3,  8'h07, 32'h55,   1, 6'd3,  6'd3,  9'd7,   32'h0,  9'd7,   32'h0};
        vecs[3]  = '{1, 1, 6'd4,  8'h02, 0, NR,    8'h00, 32'h0,    1, 6'd3,  6'd4,  ND,     32'h55, ND,     32'h0};
        vecs[4]  = '{1, 1, 6'd4,  8'h09, 0, NR,    8'h00, 32'h0,    1, 6'd3,  6'd4,  ND,     32'h55, 9'd2,   32'h0};
        vecs[5]  = '{1, 0, NR,    8'h00, 1, 6'd4,  8'h02, 32'hAA,   1, 6'd4,  NR,    9'd9,   32'h0,  ND,     32'h0};
        vecs[6]  = '{1, 1, 6'd0,  8'h01, 1, 6'd0,  8'h01, 32'hFF,   1, 6'd4,  6'd0,  9'd9,   32'hAA, ND,     32'h0};
        vecs[7]  = '{1, 1, 6'd6,  8'h11, 0, NR,    8'h00, 32'h0,    1, 6'd0,  6'd4,  ND,     32'h0,  9'd9,   32'hAA};
        vecs[8]  = '{1, 1, 6'd7,  8'h12, 0, NR,    8'h00, 32'h0,    1, 6'd6,  6'd7,  9'h11,  32'h0,  ND,     32'h0};
        vecs[9]  = '{1, 1, 6'd8,  8'h20, 1, 6'd6,  8'h33, 32'h10,   0, 6'd6,  6'd7,  9'h11,  32'h0,  9'h12,  32'h0};
        vecs[10] = '{1, 0, NR,    8'h00, 0, NR,    8'h00, 32'h0,    1, 6'd6,  6'd7,  ND,     32'h10, ND,     32'h0};
        vecs[11] = '{0, 1, 6'd10, 8'h05, 1, 6'd11, 8'h00, 32'h99,   1, 6'd8,  6'd4,  ND,     32'h0,  ND,     32'hAA};
        vecs[12] = '{1, 1, 6'd12, 8'h40, 1, 6'd12, 8'h40, 32'h12,   1, 6'd10, 6'd11, ND,     32'h0,  ND,     32'h0};
        vecs[13] = '{1, 1, 6'd13, 8'hFF, 1, NR,    8'h00, 32'hDEAD, 1, 6'd12, NR,    9'h40,  32'h12, ND,     32'h0};
        vecs[14] = '{1, 0, NR,    8'h00, 0, NR,    8'h00, 32'h0,    1, 6'd13, 6'd3,  9'hFF,  32'h0,  ND,     32'h55};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Outputs are sampled 1 time unit after the negedge, inputs then take effect at the next posedge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rdy = vecs[i].rdy; dp_en = vecs[i].dp_en; dp_rd = vecs[i].dp_rd; dp_idx = vecs[i].dp_idx;
            c_en = vecs[i].c_en; c_rd = vecs[i].c_rd; c_idx = vecs[i].c_idx; c_val = vecs[i].c_val;
            pre_judge = vecs[i].pre_judge; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_qj", i), 32'(qj), 32'(vecs[i].exp_qj));
            check($sformatf("v%0d_vj", i), vj, vecs[i].exp_vj);
            check($sformatf("v%0d_qk", i), 32'(qk), 32'(vecs[i].exp_qk));
            check($sformatf("v%0d_vk", i), vk, vecs[i].exp_vk);
        end

        // Commit bypass: x9 renamed to tag 4, then committed while being read.
        @(negedge clk);
        idle_inputs();
        dp_en = 1'b1; dp_rd = 6'd9; dp_idx = 8'd4;
        @(negedge clk);
        idle_inputs();
        c_en = 1'b1; c_rd = 6'd9; c_idx = 8'd4; c_val = 32'h77; rs2 = 6'd9;
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        check("bypass_qk", 32'(qk), 32'(ND));
        check("bypass_vk", vk, 32'h77);
`else
        check("bypass_qk", 32'(qk), 32'd4);
        check("bypass_vk", vk, 32'h0);
`endif
        @(negedge clk);
        idle_inputs();
        rs2 = 6'd9;
        #1;
        check("post_commit_qk", 32'(qk), 32'(ND));
        check("post_commit_vk", vk, 32'h77);

        // Asynchronous reset mid-cycle with x5 busy.
        @(negedge clk);
        idle_inputs();
        dp_en = 1'b1; dp_rd = 6'd5; dp_idx = 8'h21;
        @(negedge clk);
        idle_inputs();
        rs1 = 6'd5; rs2 = 6'd3;
        #1;
        check("pre_rst_qj", 32'(qj), 32'h21);
        check("pre_rst_vk", vk, 32'h55);
        #1;
        rst_n = 1'b0;
        #1;
        check("in_rst_qj", 32'(qj), 32'(ND));
        check("in_rst_vj", vj, 32'h0);
        check("in_rst_vk", vk, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_qj", 32'(qj), 32'(ND));
        check("post_rst_vj", vj, 32'h0);
        check("post_rst_vk", vk, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
